// File: rtl/opcode_sequencer.sv
// rtl/opcode_sequencer.sv - program-driven opcode source with valid/ready issue
module opcode_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int OP_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            prog_we,
  input  logic [AW-1:0]   prog_addr,
  input  logic [OP_W-1:0] prog_data,
  input  logic            start,
  input  logic            stop,
  input  logic            issue_ready,
  output logic [OP_W-1:0] opcode,
  output logic            opcode_valid,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   pc
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] ISSUE   = 2'd2;
  localparam logic [1:0] DONE_ST = 2'd3;

  localparam logic [OP_W-1:0] OP_NOP  = '0;
  localparam logic [OP_W-1:0] OP_HALT = '1;
  localparam logic [AW-1:0]   LAST_PC = AW'(DEPTH - 1);

  logic [1:0]      state;
  logic [OP_W-1:0] mem [DEPTH];
  logic [OP_W-1:0] cur_word;

  assign cur_word     = mem[pc];
  assign opcode_valid = (state == ISSUE);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE_ST);

  // Program is writable only while idle, so a run always sees a frozen image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= OP_HALT;
    end else if (prog_we && state == IDLE) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= '0;
      opcode <= '0;
    end else if (stop && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= FETCH;
            pc    <= '0;
          end
        end
        FETCH: begin
          opcode <= cur_word;
          if (cur_word == OP_HALT) begin
            state <= DONE_ST;
          end else if (cur_word == OP_NOP) begin
            if (pc == LAST_PC) state <= DONE_ST;
            else               pc    <= pc + 1'b1;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // pc never wraps: the last word ends the run after its transfer.
          if (issue_ready) begin
            if (pc == LAST_PC) begin
              state <= DONE_ST;
            end else begin
              pc    <= pc + 1'b1;
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opcode_sequencer.sv
// tb/tb_opcode_sequencer.sv - scoreboard bench for opcode_sequencer
module tb_opcode_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = 4'h0;
  logic [3:0] prog_data = 4'h0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       issue_ready = 1'b0;
  logic [3:0] opcode;
  logic       opcode_valid;
  logic       busy;
  logic       done;
  logic [3:0] pc;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  opcode_sequencer #(.DEPTH(16), .AW(4), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .stop(stop), .issue_ready(issue_ready),
    .opcode(opcode), .opcode_valid(opcode_valid), .busy(busy), .done(done), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic write_word(input int a, input int d);
    prog_addr = 4'(a);
    prog_data = 4'(d);
    prog_we = 1'b1;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // k counts cycles after the edge that sampled start (k=0 is the first FETCH)
  task automatic run(input int max_cyc, output int n_xfer, output int first_cyc,
                     output int done_cyc, output logic [3:0] first_pc);
    logic [3:0] exp;
    bit seen_done;
    n_xfer = 0; first_cyc = -1; done_cyc = -1; first_pc = 4'h0; seen_done = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (opcode_valid && first_cyc < 0) begin
        first_cyc = k;
        first_pc = pc;
      end
      if (opcode_valid && issue_ready) begin
        n_xfer++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_issue opcode=%h required none", opcode);
        end else begin
          exp = exp_q.pop_front();
          if (opcode !== exp) begin
            errors++;
            $display("FAIL issued_opcode got %h required %h", opcode, exp);
          end
        end
      end
      if (done) begin
        done_cyc = k;
        seen_done = 1;
      end
      @(posedge clk); #1;
      if (seen_done) break;
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done done=%b busy=%b required 0 0", done, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (opcode_valid) return;
      @(posedge clk); #1;
    end
    errors++;
    $display("FAIL %s_timeout valid=0 required 1", name);
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++;
    if ({opcode, opcode_valid, busy, done, pc} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 000", {opcode, opcode_valid, busy, done, pc});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_idle busy=%b required 0", busy);
    end
  endtask

  task automatic test_basic;
    int nx, fc, dc; logic [3:0] fp;
    write_word(0, 1); write_word(1, 2); write_word(2, 3); write_word(3, 15);
    exp_q.push_back(4'h1); exp_q.push_back(4'h2); exp_q.push_back(4'h3);
    issue_ready = 1'b1;
    pulse_start;
    run(60, nx, fc, dc, fp);
    checks++;
    if (nx != 3 || fc != 1 || dc != 7) begin
      errors++;
      $display("FAIL basic xfer=%0d first=%0d done=%0d required 3 1 7", nx, fc, dc);
    end
  endtask

  task automatic test_nop_skip;
    int nx, fc, dc; logic [3:0] fp;
    write_word(0, 0); write_word(1, 0); write_word(2, 2); write_word(3, 15);
    exp_q.push_back(4'h2);
    pulse_start;
    run(60, nx, fc, dc, fp);
    checks++;
    if (nx != 1 || fc != 3 || fp !== 4'd2 || dc != 5) begin
      errors++;
      $display("FAIL nop_skip xfer=%0d first=%0d pc=%0d done=%0d required 1 3 2 5", nx, fc, fp, dc);
    end
  endtask

  task automatic test_backpressure;
    int nx, fc, dc; logic [3:0] fp;
    write_word(0, 3); write_word(1, 15);
    issue_ready = 1'b0;
    pulse_start;
    wait_valid("hold");
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      checks++;
      if (opcode !== 4'h3 || opcode_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle%0d opcode=%h valid=%b required 3 1", j, opcode, opcode_valid);
      end
      @(posedge clk); #1;
    end
    issue_ready = 1'b1;
    exp_q.push_back(4'h3);
    run(20, nx, fc, dc, fp);
    checks++;
    if (nx != 1 || dc < 0) begin
      errors++;
      $display("FAIL hold_release xfer=%0d done=%0d required 1 and done", nx, dc);
    end
  endtask

  task automatic test_full_memory;
    int nx, fc, dc; logic [3:0] fp;
    for (int a = 0; a < 16; a++) begin
      write_word(a, 1);
      exp_q.push_back(4'h1);
    end
    issue_ready = 1'b1;
    pulse_start;
    run(100, nx, fc, dc, fp);
    checks++;
    if (nx != 16 || dc != 32) begin
      errors++;
      $display("FAIL full_memory xfer=%0d done=%0d required 16 32", nx, dc);
    end
  endtask

  task automatic test_stop;
    int nx, fc, dc; logic [3:0] fp;
    write_word(0, 2); write_word(1, 15);
    issue_ready = 1'b0;
    pulse_start;
    wait_valid("stop");
    prog_addr = 4'h0; prog_data = 4'h7; prog_we = 1'b1;
    @(posedge clk); #1;
    prog_we = 1'b0;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || opcode_valid !== 1'b0 || done !== 1'b0 || pc !== 4'd0) begin
      errors++;
      $display("FAIL stop_state busy=%b valid=%b done=%b pc=%0d required 0 0 0 0", busy, opcode_valid, done, pc);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL stop_no_done done=%b required 0", done);
    end
    exp_q.push_back(4'h2);
    issue_ready = 1'b1;
    pulse_start;
    run(20, nx, fc, dc, fp);
    checks++;
    if (nx != 1 || dc != 3) begin
      errors++;
      $display("FAIL stop_rerun xfer=%0d done=%0d required 1 3", nx, dc);
    end
  endtask

  task automatic test_async_reset;
    int nx, fc, dc; logic [3:0] fp;
    write_word(0, 4); write_word(1, 15);
    issue_ready = 1'b0;
    pulse_start;
    wait_valid("areset");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (opcode_valid !== 1'b0 || busy !== 1'b0 || pc !== 4'd0 || opcode !== 4'h0) begin
      errors++;
      $display("FAIL async_reset valid=%b busy=%b pc=%0d opcode=%h required 0 0 0 0", opcode_valid, busy, pc, opcode);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue_ready = 1'b1;
    pulse_start;
    run(10, nx, fc, dc, fp);
    checks++;
    if (nx != 0 || dc != 1) begin
      errors++;
      $display("FAIL reset_mem_halt xfer=%0d done=%0d required 0 1", nx, dc);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_nop_skip;
    test_backpressure;
    test_full_memory;
    test_stop;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
